// File: rtl/alu_pkg.sv
// Shared ALU op encodings, legality helper and issue-controller FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOT = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic err;
    } rsp_flags_t;

    function automatic logic is_legal(input logic [2:0] op);
        return op <= 3'(OP_NOT);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command and response channels between the host/sequencer and alu_issue_ctrl.
interface alu_issue_ctrl_if #(
    parameter int NREG = 4
);
    localparam int RA_W = $clog2(NREG);

    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [RA_W-1:0] cmd_src1;
    logic [RA_W-1:0] cmd_src2;
    logic [RA_W-1:0] cmd_dst;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [3:0]      rsp_data;
    logic [RA_W-1:0] rsp_dst;
    logic            rsp_zero;
    logic            rsp_carry;
    logic            rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_dst, rsp_zero, rsp_carry, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_dst, rsp_zero, rsp_carry, rsp_err
    );

endinterface

// File: rtl/alu_regfile.sv
// NREG x 4-bit register file: two async read ports, host + writeback write ports.
module alu_regfile #(
    parameter int NREG = 4,
    parameter int RA_W = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RA_W-1:0] rd_addr0,
    output logic [3:0]      rd_data0,
    input  logic [RA_W-1:0] rd_addr1,
    output logic [3:0]      rd_data1,
    input  logic            host_we,
    input  logic [RA_W-1:0] host_addr,
    input  logic [3:0]      host_data,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_addr,
    input  logic [3:0]      wb_data
);

    logic [NREG-1:0][3:0] rf;

    assign rd_data0 = rf[rd_addr0];
    assign rd_data1 = rf[rd_addr1];

    // Writeback beats a same-cycle host write to the same register.
    for (genvar g = 0; g < NREG; g++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                rf[g] <= 4'd0;
            else if (wb_we && wb_addr == RA_W'(g))
                rf[g] <= wb_data;
            else if (host_we && host_addr == RA_W'(g))
                rf[g] <= host_data;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues register-addressed commands to a combinational 4-bit ALU, writes back
// the result and returns a status response; one command in flight.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(NREG)-1:0]  wr_addr,
    input  logic [3:0]               wr_data,
    alu_issue_ctrl_if.slave          bus,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [2:0]               alu_sel,
    input  logic [3:0]               alu_result
);

    localparam int RA_W = $clog2(NREG);

    state_e          state, state_nx;
    logic            accept, wb_we;
    logic [2:0]      op_q;
    logic [RA_W-1:0] dst_q;
    logic [3:0]      a_q, b_q, rd_a, rd_b;
    logic [4:0]      sum5;
    logic            carry_c;
    rsp_flags_t      flags;

    alu_regfile #(.NREG(NREG), .RA_W(RA_W)) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr0  (bus.cmd_src1),
        .rd_data0  (rd_a),
        .rd_addr1  (bus.cmd_src2),
        .rd_data1  (rd_b),
        .host_we   (wr_en),
        .host_addr (wr_addr),
        .host_data (wr_data),
        .wb_we     (wb_we),
        .wb_addr   (dst_q),
        .wb_data   (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (accept) state_nx = is_legal(bus.cmd_op) ? S_ISSUE : S_RESP;
            S_ISSUE:   state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_RESP;
            S_RESP:    if (bus.rsp_ready) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state == S_IDLE);
        bus.rsp_valid = (state == S_RESP);
        wb_we         = (state == S_CAPTURE);
    end

    assign accept = bus.cmd_valid && bus.cmd_ready;

    // Carry/borrow come from the latched operands, not from the ALU.
    assign sum5    = {1'b0, a_q} + {1'b0, b_q};
    assign carry_c = (op_q == 3'(OP_ADD)) ? sum5[4] :
                     (op_q == 3'(OP_SUB)) ? (a_q < b_q) : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= 3'd0;
            dst_q        <= '0;
            a_q          <= 4'd0;
            b_q          <= 4'd0;
            alu_a        <= 4'd0;
            alu_b        <= 4'd0;
            alu_sel      <= 3'd0;
            bus.rsp_data <= 4'd0;
            bus.rsp_dst  <= '0;
            flags        <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_q  <= bus.cmd_op;
                    dst_q <= bus.cmd_dst;
                    a_q   <= rd_a;
                    b_q   <= rd_b;
                    if (!is_legal(bus.cmd_op)) begin
                        bus.rsp_data <= 4'd0;
                        bus.rsp_dst  <= bus.cmd_dst;
                        flags        <= '{zero: 1'b1, carry: 1'b0, err: 1'b1};
                    end
                end
                S_ISSUE: begin
                    alu_a   <= a_q;
                    alu_b   <= b_q;
                    alu_sel <= op_q;
                end
                S_CAPTURE: begin
                    bus.rsp_data <= alu_result;
                    bus.rsp_dst  <= dst_q;
                    flags        <= '{zero: (alu_result == 4'd0), carry: carry_c, err: 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_zero  = flags.zero;
    assign bus.rsp_carry = flags.carry;
    assign bus.rsp_err   = flags.err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU.
module tb_alu_issue_ctrl;

    localparam int NREG = 4;
    localparam int RA_W = $clog2(NREG);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [RA_W-1:0] wr_addr = '0;
    logic [3:0]      wr_data = '0;
    logic [3:0]      alu_a, alu_b, alu_result;
    logic [2:0]      alu_sel;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl_if #(.NREG(NREG)) bus ();

    alu_issue_ctrl #(.NREG(NREG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = 4'd0;
        case (alu_sel)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = ~alu_a;
            default: alu_result = 4'd0;
        endcase
    end

    typedef struct {
        logic [2:0]      op;
        logic [RA_W-1:0] s1, s2, d;
        logic [3:0]      va, vb, data;
        logic            z, c;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [RA_W-1:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) tick();
        check("cmd_ready_wait", bus.cmd_ready, 1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [RA_W-1:0] s1,
                         input logic [RA_W-1:0] s2, input logic [RA_W-1:0] d);
        wait_ready();
        bus.cmd_valid = 1'b1; bus.cmd_op = op;
        bus.cmd_src1 = s1; bus.cmd_src2 = s2; bus.cmd_dst = d;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) tick();
        check("rsp_valid_wait", bus.rsp_valid, 1);
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    // OR of a register with itself back into itself reads it without changing it.
    task automatic read_reg(input logic [RA_W-1:0] r, output logic [3:0] v);
        issue(3'b011, r, r, r);
        wait_rsp();
        v = bus.rsp_data;
        consume();
    endtask

    initial begin
        logic [3:0] v;
        logic [3:0] sa, sb;
        logic [2:0] ss;

        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_src1 = '0;
        bus.cmd_src2 = '0; bus.cmd_dst = '0; bus.rsp_ready = 1'b0;

        //            op    s1 s2 d  va  vb  data z  c
        vt[0] = '{3'd0, 1, 2, 3, 9,  8,  1,  0, 1};
        vt[1] = '{3'd1, 0, 1, 2, 5,  5,  0,  1, 0};
        vt[2] = '{3'd1, 0, 1, 2, 3,  5,  14, 0, 1};
        vt[3] = '{3'd2, 2, 3, 0, 12, 10, 8,  0, 0};
        vt[4] = '{3'd3, 3, 0, 1, 4,  1,  5,  0, 0};
        vt[5] = '{3'd4, 1, 2, 1, 15, 3,  0,  1, 0};
        vt[6] = '{3'd0, 0, 3, 2, 7,  8,  15, 0, 0};
        vt[7] = '{3'd1, 2, 1, 3, 9,  2,  7,  0, 0};
        vt[8] = '{3'd0, 1, 0, 2, 15, 1,  0,  1, 1};

        #12;
        check("reset_cmd_ready", bus.cmd_ready, 1);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_alu_sel", alu_sel, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_rsp_data", bus.rsp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Add with carry: exact latency
        host_write(1, 9);
        host_write(2, 8);
        issue(3'b000, 1, 2, 3);
        check("add_cmd_ready_busy", bus.cmd_ready, 0);
        tick();
        check("add_alu_a", alu_a, 9);
        check("add_alu_b", alu_b, 8);
        check("add_alu_sel", alu_sel, 0);
        check("add_no_rsp_yet", bus.rsp_valid, 0);
        tick();
        check("add_rsp_valid", bus.rsp_valid, 1);
        check("add_rsp_data", bus.rsp_data, 1);
        check("add_rsp_carry", bus.rsp_carry, 1);
        check("add_rsp_zero", bus.rsp_zero, 0);
        check("add_rsp_dst", bus.rsp_dst, 3);
        consume();
        check("add_ready_after", bus.cmd_ready, 1);
        read_reg(3, v);
        check("add_rf3", v, 1);

        foreach (vt[i]) begin
            host_write(vt[i].s1, vt[i].va);
            host_write(vt[i].s2, vt[i].vb);
            issue(vt[i].op, vt[i].s1, vt[i].s2, vt[i].d);
            wait_rsp();
            check($sformatf("vec%0d_data", i), bus.rsp_data, vt[i].data);
            check($sformatf("vec%0d_zero", i), bus.rsp_zero, vt[i].z);
            check($sformatf("vec%0d_carry", i), bus.rsp_carry, vt[i].c);
            check($sformatf("vec%0d_err", i), bus.rsp_err, 0);
            check($sformatf("vec%0d_dst", i), bus.rsp_dst, vt[i].d);
            consume();
            read_reg(vt[i].d, v);
            check($sformatf("vec%0d_rf", i), v, vt[i].data);
        end

        // Backpressure: response held, a pending command must wait
        host_write(0, 6);
        host_write(1, 3);
        issue(3'b001, 0, 1, 2);
        wait_rsp();
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'b000;
        bus.cmd_src1 = 0; bus.cmd_src2 = 1; bus.cmd_dst = 3;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_data", bus.rsp_data, 3);
            check("bp_cmd_ready", bus.cmd_ready, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("bp_ready_after_rsp", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        check("bp_accepted_next", bus.cmd_ready, 0);
        wait_rsp();
        check("bp_second_data", bus.rsp_data, 9);
        check("bp_second_dst", bus.rsp_dst, 3);
        consume();

        // Illegal op: one-cycle error response, ALU and RF untouched
        host_write(1, 11);
        sa = alu_a; sb = alu_b; ss = alu_sel;
        issue(3'b110, 2, 3, 1);
        check("ill_rsp_valid", bus.rsp_valid, 1);
        check("ill_rsp_err", bus.rsp_err, 1);
        check("ill_rsp_data", bus.rsp_data, 0);
        check("ill_rsp_zero", bus.rsp_zero, 1);
        check("ill_rsp_carry", bus.rsp_carry, 0);
        check("ill_rsp_dst", bus.rsp_dst, 1);
        check("ill_alu_a", alu_a, sa);
        check("ill_alu_b", alu_b, sb);
        check("ill_alu_sel", alu_sel, ss);
        consume();
        read_reg(1, v);
        check("ill_rf_unchanged", v, 11);

        // Host write to dst during CAPTURE loses to the writeback
        host_write(0, 4);
        host_write(1, 1);
        host_write(2, 9);
        issue(3'b011, 0, 1, 2);
        tick();
        host_write(2, 7);
        check("col_rsp_data", bus.rsp_data, 5);
        consume();
        read_reg(2, v);
        check("col_rf2", v, 5);

        // Host write to src1 in the accept cycle: operand uses the old value
        wait_ready();
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'b011;
        bus.cmd_src1 = 0; bus.cmd_src2 = 1; bus.cmd_dst = 3;
        wr_en = 1'b1; wr_addr = 0; wr_data = 8;
        tick();
        bus.cmd_valid = 1'b0; wr_en = 1'b0;
        wait_rsp();
        check("acc_wr_old_operand", bus.rsp_data, 5);
        consume();
        read_reg(0, v);
        check("acc_wr_rf0_new", v, 8);

        // Reset in the middle of RESP
        issue(3'b001, 0, 1, 2);
        wait_rsp();
        check("rst_pre_sel", alu_sel, 1);
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_alu_a", alu_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int r = 0; r < NREG; r++) begin
            read_reg(RA_W'(r), v);
            check($sformatf("rst_rf%0d", r), v, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
